// File: rtl/mem_parity_det_pkg.sv
// ---------------------------------------------------------------------------
// mem_ed_pkg
// Shared types and constants for the memory sense odd-parity checker.
//   state_t   : read sequencer states (IDLE, SHIFT, CHECK)
//   SYL_*     : serial syllable geometry (13 data bits + 1 parity bit)
//   CNT_W     : width of the saturating error counter
//   PAIR_*    : module pair codes carried on PAIR
//   ed_index  : maps (pair, channel) to the EDnX/EDnY bit it drives
// ---------------------------------------------------------------------------
package mem_ed_pkg;

    localparam int SYL_DATA  = 13;
    localparam int SYL_BITS  = SYL_DATA + 1;
    localparam int BIT_CNT_W = $clog2(SYL_BITS);
    localparam int CNT_W     = 4;

    // Data plus parity must carry an odd number of ones.
    localparam logic PAR_ODD = 1'b1;

    localparam logic [1:0] PAIR_MZO = 2'd0;
    localparam logic [1:0] PAIR_MTT = 2'd1;
    localparam logic [1:0] PAIR_MFF = 2'd2;
    localparam logic [1:0] PAIR_MSS = 2'd3;

    // Channel A serves the even module of a pair, channel B the odd one.
    localparam logic CHAN_A = 1'b0;
    localparam logic CHAN_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    function automatic logic [2:0] ed_index(input logic [1:0] pair, input logic chan);
        return {pair, chan};
    endfunction

endpackage

// File: rtl/mem_parity_det_if.sv
// ---------------------------------------------------------------------------
// mem_parity_det_if
// Bus bundle between the sense amplifiers / sequencer and the parity checker.
//   control : bit_stb, read_start, word, pair, chk_en, clr
//   sense   : sax, say (channel A X/Y trees), sbx, sby (channel B X/Y trees)
//   status  : edx, edy (sticky per-module error flags), busy, done, errcnt
// master drives control/sense and observes status; slave is the checker.
// ---------------------------------------------------------------------------
interface mem_parity_det_if;
    import mem_ed_pkg::*;

    logic             bit_stb;
    logic             read_start;
    logic             word;
    logic [1:0]       pair;
    logic             chk_en;
    logic             sax;
    logic             say;
    logic             sbx;
    logic             sby;
    logic             clr;
    logic [7:0]       edx;
    logic [7:0]       edy;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] errcnt;

    modport master (
        output bit_stb, read_start, word, pair, chk_en,
        output sax, say, sbx, sby, clr,
        input  edx, edy, busy, done, errcnt
    );

    modport slave (
        input  bit_stb, read_start, word, pair, chk_en,
        input  sax, say, sbx, sby, clr,
        output edx, edy, busy, done, errcnt
    );

endinterface

// File: rtl/mem_parity_det_acc.sv
// ---------------------------------------------------------------------------
// serial_parity_acc
// One serial parity tree. XORs in one sense bit per enabled cycle; on the
// parity bit it records a syllable error if the running XOR is not odd.
// The error is sticky across the syllables of a read and cleared at start.
//   clk, rstn : clock, asynchronous active-low reset
//   bit_in    : serial sense bit
//   en        : consume bit_in this cycle
//   clr       : read start, clears accumulator and error
//   last      : bit_in is the parity bit of the current syllable
//   err       : any syllable of this read failed odd parity
// ---------------------------------------------------------------------------
module serial_parity_acc
    import mem_ed_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic bit_in,
    input  logic en,
    input  logic clr,
    input  logic last,
    output logic err
);

    logic acc;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order blocks are evaluated in.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= 1'b0;
            err <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
            err <= 1'b0;
        end else if (en) begin
            if (last) begin
                if ((acc ^ bit_in) != PAR_ODD) begin
                    err <= 1'b1;
                end
                acc <= 1'b0;
            end else begin
                acc <= acc ^ bit_in;
            end
        end
    end

endmodule

// File: rtl/mem_parity_det.sv
// ---------------------------------------------------------------------------
// mem_parity_det
// Serial odd-parity checker on the memory sense outputs. Checks channel A
// (even module) and channel B (odd module) of the selected pair at once,
// each with independent X and Y trees, and raises sticky EDnX/EDnY flags
// that the downstream switchover logic compares.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : mem_parity_det_if.slave (control, sense inputs, status)
// ---------------------------------------------------------------------------
module mem_parity_det
    import mem_ed_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    mem_parity_det_if.slave         bus
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SYL_BITS - 1);

    state_t               state_q;
    state_t               state_n;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic                 syl_cnt_q;
    logic                 word_q;
    logic [1:0]           pair_q;
    logic                 chk_en_q;
    logic [7:0]           edx_q;
    logic [7:0]           edy_q;
    logic [CNT_W-1:0]     errcnt_q;

    logic                 start;
    logic                 shift_en;
    logic                 last_bit;
    logic                 in_check;
    logic                 err_ax;
    logic                 err_ay;
    logic                 err_bx;
    logic                 err_by;
    logic [7:0]           edx_n;
    logic [7:0]           edy_n;
    logic [CNT_W-1:0]     errcnt_n;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n  = state_q;
        start    = 1'b0;
        shift_en = 1'b0;
        in_check = 1'b0;
        last_bit = (bit_cnt_q == LAST_BIT);
        case (state_q)
            IDLE: begin
                if (bus.read_start) begin
                    start   = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = bus.bit_stb;
                // Final syllable is index 1 for a word read, 0 otherwise.
                if (bus.bit_stb && last_bit && (syl_cnt_q == word_q)) begin
                    state_n = CHECK;
                end
            end
            CHECK: begin
                in_check = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_q <= '0;
            syl_cnt_q <= 1'b0;
            word_q    <= 1'b0;
            pair_q    <= PAIR_MZO;
            chk_en_q  <= 1'b0;
        end else if (start) begin
            bit_cnt_q <= '0;
            syl_cnt_q <= 1'b0;
            word_q    <= bus.word;
            pair_q    <= bus.pair;
            chk_en_q  <= bus.chk_en;
        end else if (shift_en) begin
            if (last_bit) begin
                bit_cnt_q <= '0;
                syl_cnt_q <= ~syl_cnt_q;
            end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Parity trees
    // ------------------------------------------------------------------
    serial_parity_acc u_acc_ax (
        .clk(clk), .rstn(rstn), .bit_in(bus.sax), .en(shift_en),
        .clr(start), .last(last_bit), .err(err_ax)
    );
    serial_parity_acc u_acc_ay (
        .clk(clk), .rstn(rstn), .bit_in(bus.say), .en(shift_en),
        .clr(start), .last(last_bit), .err(err_ay)
    );
    serial_parity_acc u_acc_bx (
        .clk(clk), .rstn(rstn), .bit_in(bus.sbx), .en(shift_en),
        .clr(start), .last(last_bit), .err(err_bx)
    );
    serial_parity_acc u_acc_by (
        .clk(clk), .rstn(rstn), .bit_in(bus.sby), .en(shift_en),
        .clr(start), .last(last_bit), .err(err_by)
    );

    // ------------------------------------------------------------------
    // Flags and error counter. CLR is applied first so a coincident CHECK
    // update lands on a cleared base and wins.
    // ------------------------------------------------------------------
    always_comb begin
        edx_n    = bus.clr ? '0 : edx_q;
        edy_n    = bus.clr ? '0 : edy_q;
        errcnt_n = bus.clr ? '0 : errcnt_q;
        if (in_check && chk_en_q) begin
            edx_n[ed_index(pair_q, CHAN_A)] = edx_n[ed_index(pair_q, CHAN_A)] | err_ax;
            edx_n[ed_index(pair_q, CHAN_B)] = edx_n[ed_index(pair_q, CHAN_B)] | err_bx;
            edy_n[ed_index(pair_q, CHAN_A)] = edy_n[ed_index(pair_q, CHAN_A)] | err_ay;
            edy_n[ed_index(pair_q, CHAN_B)] = edy_n[ed_index(pair_q, CHAN_B)] | err_by;
            if ((err_ax | err_ay | err_bx | err_by) && (errcnt_n != '1)) begin
                errcnt_n = errcnt_n + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edx_q    <= '0;
            edy_q    <= '0;
            errcnt_q <= '0;
        end else begin
            edx_q    <= edx_n;
            edy_q    <= edy_n;
            errcnt_q <= errcnt_n;
        end
    end

    assign bus.edx    = edx_q;
    assign bus.edy    = edy_q;
    assign bus.errcnt = errcnt_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == CHECK);

endmodule

// File: tb/tb_mem_parity_det.sv
// ---------------------------------------------------------------------------
// tb_mem_parity_det
// Self-checking bench for mem_parity_det. Each read is described as whole
// 14-bit syllables per channel; the reference decides errors by counting
// ones in each syllable and keeps its own flag/counter image.
// ---------------------------------------------------------------------------
module tb_mem_parity_det;
    import mem_ed_pkg::*;

    logic clk;
    logic rstn;

    mem_parity_det_if bus ();

    mem_parity_det dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference image of the checker outputs.
    logic [7:0] m_edx;
    logic [7:0] m_edy;
    int         m_cnt;

    // Current read description. Channel order: 0=AX 1=AY 2=BX 3=BY.
    logic [SYL_BITS-1:0] cur_syl [4][2];
    logic                cur_word;
    logic [1:0]          cur_pair;
    logic                cur_chk;
    int                  cur_gap;
    logic                cur_restart;
    logic                cur_clr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Random data with correct odd parity unless the mask marks a syllable bad.
    task automatic fill(input logic w, input logic [1:0] p, input logic c, input logic [7:0] bad);
        logic [SYL_DATA-1:0] data;
        logic                par;
        for (int ch = 0; ch < 4; ch++) begin
            for (int s = 0; s < 2; s++) begin
                data = SYL_DATA'($urandom);
                par  = ~(^data);
                if (bad[ch*2+s]) par = ~par;
                cur_syl[ch][s] = {par, data};
            end
        end
        cur_word    = w;
        cur_pair    = p;
        cur_chk     = c;
        cur_gap     = 1;
        cur_restart = 1'b0;
        cur_clr     = 1'b0;
    endtask

    task automatic model_update();
        logic [3:0] e;
        int         nsyl;
        nsyl = cur_word ? 2 : 1;
        for (int ch = 0; ch < 4; ch++) begin
            e[ch] = 1'b0;
            for (int s = 0; s < nsyl; s++) begin
                if (($countones(cur_syl[ch][s]) % 2) == 0) e[ch] = 1'b1;
            end
        end
        if (cur_clr) begin
            m_edx = '0;
            m_edy = '0;
            m_cnt = 0;
        end
        if (cur_chk) begin
            if (e[0]) m_edx[2*cur_pair]   = 1'b1;
            if (e[1]) m_edy[2*cur_pair]   = 1'b1;
            if (e[2]) m_edx[2*cur_pair+1] = 1'b1;
            if (e[3]) m_edy[2*cur_pair+1] = 1'b1;
            if (|e && m_cnt < 15) m_cnt++;
        end
    endtask

    task automatic drive_idle_sense();
        bus.sax = 1'($urandom);
        bus.say = 1'($urandom);
        bus.sbx = 1'($urandom);
        bus.sby = 1'($urandom);
    endtask

    task automatic start_read();
        bus.read_start = 1'b1;
        bus.word       = cur_word;
        bus.pair       = cur_pair;
        bus.chk_en     = cur_chk;
        @(negedge clk);
        bus.read_start = 1'b0;
        // Scramble the control inputs to show they were latched at start.
        bus.word   = 1'($urandom);
        bus.pair   = 2'($urandom);
        bus.chk_en = 1'($urandom);
    endtask

    // Called at a negedge with the checker idle; returns at the negedge after CHECK.
    task automatic run_read(input string tag);
        int   nbits;
        int   s;
        int   b;
        logic seq_ok;
        nbits  = cur_word ? 2*SYL_BITS : SYL_BITS;
        seq_ok = 1'b1;
        start_read();
        for (int n = 0; n < nbits; n++) begin
            for (int g = 1; g < cur_gap; g++) begin
                bus.bit_stb = 1'b0;
                drive_idle_sense();
                if (cur_restart && g == 1 && (n == 5 || n == nbits-1)) bus.read_start = 1'b1;
                @(negedge clk);
                bus.read_start = 1'b0;
                if (bus.done !== 1'b0 || bus.busy !== 1'b1) seq_ok = 1'b0;
            end
            s = n / SYL_BITS;
            b = n % SYL_BITS;
            bus.bit_stb = 1'b1;
            bus.sax = cur_syl[0][s][b];
            bus.say = cur_syl[1][s][b];
            bus.sbx = cur_syl[2][s][b];
            bus.sby = cur_syl[3][s][b];
            @(negedge clk);
            bus.bit_stb = 1'b0;
            if (n < nbits-1 && (bus.done !== 1'b0 || bus.busy !== 1'b1)) seq_ok = 1'b0;
        end
        check({tag, "_seq"}, 32'(seq_ok), 32'd1);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_chk"}, 32'(bus.busy), 32'd1);
        bus.clr = cur_clr;
        @(negedge clk);
        bus.clr = 1'b0;
        model_update();
        check({tag, "_done_end"}, 32'(bus.done), 32'd0);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        check({tag, "_edx"}, 32'(bus.edx), 32'(m_edx));
        check({tag, "_edy"}, 32'(bus.edy), 32'(m_edy));
        check({tag, "_cnt"}, 32'(bus.errcnt), 32'(m_cnt));
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        m_edx = '0;
        m_edy = '0;
        m_cnt = 0;
        check("clr_edx", 32'(bus.edx), 32'd0);
        check("clr_cnt", 32'(bus.errcnt), 32'd0);
    endtask

    initial begin
        rstn           = 1'b0;
        bus.bit_stb    = 1'b0;
        bus.read_start = 1'b0;
        bus.word       = 1'b0;
        bus.pair       = 2'd0;
        bus.chk_en     = 1'b0;
        bus.clr        = 1'b0;
        bus.sax        = 1'b0;
        bus.say        = 1'b0;
        bus.sbx        = 1'b0;
        bus.sby        = 1'b0;
        m_edx          = '0;
        m_edy          = '0;
        m_cnt          = 0;
        repeat (3) @(negedge clk);
        check("rst_edx", 32'(bus.edx), 32'd0);
        check("rst_edy", 32'(bus.edy), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_cnt", 32'(bus.errcnt), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // BIT_STB in IDLE must be ignored.
        bus.bit_stb = 1'b1;
        repeat (4) @(negedge clk);
        bus.bit_stb = 1'b0;
        check("idle_stb_busy", 32'(bus.busy), 32'd0);

        // Clean read: data 13'h0001, parity 0 on every channel.
        fill(1'b0, PAIR_MTT, 1'b1, 8'h00);
        for (int ch = 0; ch < 4; ch++) cur_syl[ch][0] = {1'b0, 13'h0001};
        run_read("clean");
        check("clean_edx_k", 32'(bus.edx), 32'h00);

        // Single error on syllable 1 of SBX, pair MSS.
        fill(1'b1, PAIR_MSS, 1'b1, 8'h20);
        run_read("single");
        check("single_edx_k", 32'(bus.edx), 32'h80);
        check("single_edy_k", 32'(bus.edy), 32'h00);
        check("single_cnt_k", 32'(bus.errcnt), 32'd1);
        fill(1'b1, PAIR_MSS, 1'b1, 8'h00);
        run_read("sticky");
        check("sticky_edx_k", 32'(bus.edx), 32'h80);

        // Dual error on channel A, pair MZO: data 0 with parity 0.
        pulse_clr();
        fill(1'b0, PAIR_MZO, 1'b1, 8'h00);
        cur_syl[0][0] = '0;
        cur_syl[1][0] = '0;
        run_read("dual");
        check("dual_edx_k", 32'(bus.edx), 32'h01);
        check("dual_edy_k", 32'(bus.edy), 32'h01);
        pulse_clr();
        cur_chk = 1'b0;
        run_read("dual_off");
        check("dual_off_edx_k", 32'(bus.edx), 32'h00);
        check("dual_off_cnt_k", 32'(bus.errcnt), 32'd0);

        // Gapped strobes with restart attempts during SHIFT.
        fill(1'b1, PAIR_MFF, 1'b1, 8'h00);
        cur_gap     = 3;
        cur_restart = 1'b1;
        run_read("gap");

        // Saturation: 16 erroneous reads on random pairs.
        for (int i = 0; i < 16; i++) begin
            fill(1'($urandom), 2'($urandom), 1'b1, 8'($urandom_range(1, 255)) | 8'h01);
            run_read("sat");
        end
        check("sat_cnt_k", 32'(bus.errcnt), 32'd15);

        // CLR coincident with an erroneous CHECK on pair MFF channel B.
        fill(1'b0, PAIR_MFF, 1'b1, 8'h10);
        cur_clr = 1'b1;
        run_read("clr_chk");
        check("clr_chk_edx_k", 32'(bus.edx), 32'h20);
        check("clr_chk_edy_k", 32'(bus.edy), 32'h00);
        check("clr_chk_cnt_k", 32'(bus.errcnt), 32'd1);

        // Reset mid-SHIFT at bit 9 of syllable 0 on an all-error read.
        fill(1'b1, PAIR_MFF, 1'b1, 8'hFF);
        start_read();
        for (int n = 0; n < 9; n++) begin
            bus.bit_stb = 1'b1;
            bus.sax = cur_syl[0][0][n];
            bus.say = cur_syl[1][0][n];
            bus.sbx = cur_syl[2][0][n];
            bus.sby = cur_syl[3][0][n];
            @(negedge clk);
        end
        bus.bit_stb = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_edx", 32'(bus.edx), 32'd0);
        check("mid_rst_edy", 32'(bus.edy), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_cnt", 32'(bus.errcnt), 32'd0);
        @(negedge clk);
        rstn  = 1'b1;
        m_edx = '0;
        m_edy = '0;
        m_cnt = 0;
        @(negedge clk);
        fill(1'b1, PAIR_MFF, 1'b1, 8'h00);
        run_read("post_rst");

        // Randomised reads, back to back.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] bad;
            bad = '0;
            for (int k = 0; k < 8; k++) bad[k] = ($urandom_range(0, 5) == 0);
            fill(1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0), bad);
            cur_gap     = $urandom_range(1, 3);
            cur_restart = 1'($urandom);
            cur_clr     = ($urandom_range(0, 7) == 0);
            run_read("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
